// File: rtl/d_reg_using_t.sv
// d_reg_using_t: D register built from toggle cells (T = D ^ Q) with switching-activity counters
module d_reg_using_t #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             clr,
  input  logic             clr_stats,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_last,
  output logic             changed,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [CNT_W-1:0] load_cnt,
  output logic             cnt_sat
);
  logic [WIDTH-1:0] t_next;
  logic [CNT_W:0]   pop, sum;
  always_comb begin
    t_next = clr ? q : (en ? d ^ q : '0);
    pop = '0;
    for (int k = 0; k < WIDTH; k++) pop += (CNT_W+1)'(t_next[k]);
    sum = {1'b0, toggle_cnt} + pop;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q          <= '0;
      t_last     <= '0;
      changed    <= 1'b0;
      toggle_cnt <= '0;
      load_cnt   <= '0;
      cnt_sat    <= 1'b0;
    end else begin
      q       <= q ^ t_next;
      t_last  <= t_next;
      changed <= |t_next;
      // a stats clear discards this edge's increments
      toggle_cnt <= clr_stats ? '0 : (sum[CNT_W] ? '1 : sum[CNT_W-1:0]);
      cnt_sat    <= !clr_stats && (cnt_sat || sum[CNT_W]);
      load_cnt   <= clr_stats ? '0 : load_cnt + CNT_W'(en && !clr);
    end
endmodule
